// File: rtl/router_fsm_ctrl.sv
// Control FSM of the 1x3 packet router: header decode, payload load, FIFO-full
// stalls and parity check, with Moore-decoded status and back-pressure outputs.
module router_fsm_ctrl (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic       parity_done,
   input  logic [1:0] data_in,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       fifo_full,
   input  logic       low_pkt_valid,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   output logic       busy,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] addr_reg;

   // Padded to four entries so address 3 selects a constant 0 instead of X.
   logic [3:0] soft_reset_vec;
   logic [3:0] fifo_empty_vec;
   logic       soft_reset_hit;

   assign soft_reset_vec = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
   assign fifo_empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_reset_hit = soft_reset_vec[addr_reg];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg <= DECODE_ADDRESS;
         addr_reg  <= 2'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == DECODE_ADDRESS && pkt_valid)
            addr_reg <= data_in;
      end
   end

   always_comb begin
      state_next = state_reg;
      // An addressed soft reset overrides every other transition.
      if (state_reg != DECODE_ADDRESS && soft_reset_hit) begin
         state_next = DECODE_ADDRESS;
      end else begin
         case (state_reg)
            DECODE_ADDRESS: begin
               if (pkt_valid && data_in != 2'd3)
                  state_next = fifo_empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)
                  state_next = FIFO_FULL_STATE;
               else if (!pkt_valid)
                  state_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!fifo_full)
                  state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)
                  state_next = DECODE_ADDRESS;
               else if (low_pkt_valid)
                  state_next = LOAD_PARITY;
               else
                  state_next = LOAD_DATA;
            end
            LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
               if (fifo_empty_vec[addr_reg])
                  state_next = LOAD_FIRST_DATA;
            end
            default: state_next = DECODE_ADDRESS;
         endcase
      end
   end

   assign detect_add    = (state_reg == DECODE_ADDRESS);
   assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
   assign ld_state      = (state_reg == LOAD_DATA);
   assign laf_state     = (state_reg == LOAD_AFTER_FULL);
   assign full_state    = (state_reg == FIFO_FULL_STATE);
   assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_PARITY) ||
                          (state_reg == LOAD_AFTER_FULL);
   assign busy          = !((state_reg == DECODE_ADDRESS) || (state_reg == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: directed scenarios with literal
// expected output sequences, then randomized traffic against a reference model.
module tb_router_fsm_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid, parity_done, fifo_full, low_pkt_valid;
   logic [1:0] data_in;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       rst_int_reg, write_enb_reg;

   int n_cmp = 0;
   int n_err = 0;

   // Output vector: {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
   localparam logic [7:0] O_DA  = 8'b1000_0000;
   localparam logic [7:0] O_LFD = 8'b0100_0001;
   localparam logic [7:0] O_LD  = 8'b0010_0010;
   localparam logic [7:0] O_LAF = 8'b0001_0011;
   localparam logic [7:0] O_FFS = 8'b0000_1001;
   localparam logic [7:0] O_LP  = 8'b0000_0011;
   localparam logic [7:0] O_CPE = 8'b0000_0101;
   localparam logic [7:0] O_WTE = 8'b0000_0001;

   localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7;

   int         m_state;
   logic [1:0] m_addr;

   router_fsm_ctrl dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .busy(busy),
      .parity_done(parity_done), .data_in(data_in),
      .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
      .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid),
      .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
      .write_enb_reg(write_enb_reg)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] outs();
      return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};
   endfunction

   function automatic logic [7:0] exp_of(input int s);
      case (s)
         S_DA:    return O_DA;
         S_LFD:   return O_LFD;
         S_LD:    return O_LD;
         S_FFS:   return O_FFS;
         S_LAF:   return O_LAF;
         S_LP:    return O_LP;
         S_CPE:   return O_CPE;
         default: return O_WTE;
      endcase
   endfunction

   // Reference model: next state from the current inputs and model state.
   function automatic int model_next();
      logic [2:0] sr;
      logic [2:0] emp;
      sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
      emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
      if (m_state != S_DA && m_addr != 2'd3 && sr[m_addr]) return S_DA;
      case (m_state)
         S_DA: begin
            if (pkt_valid && data_in != 2'd3) return emp[data_in] ? S_LFD : S_WTE;
            return S_DA;
         end
         S_LFD: return S_LD;
         S_LD:  return fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
         S_FFS: return fifo_full ? S_FFS : S_LAF;
         S_LAF: return parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
         S_LP:  return S_CPE;
         S_CPE: return fifo_full ? S_FFS : S_DA;
         default: return (m_addr != 2'd3 && emp[m_addr]) ? S_LFD : S_WTE;
      endcase
   endfunction

   // Drive inputs, advance one clock, and advance the model in step.
   task automatic apply(input logic pv, input logic [1:0] din, input logic [2:0] emp,
                        input logic full, input logic lpv, input logic pd, input logic [2:0] sr);
      int nxt;
      pkt_valid = pv;
      data_in = din;
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
      fifo_full = full;
      low_pkt_valid = lpv;
      parity_done = pd;
      {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
      nxt = model_next();
      if (m_state == S_DA && pv) m_addr = din;
      @(posedge clock);
      #1;
      m_state = nxt;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      pkt_valid = 0; data_in = 0; fifo_full = 0; low_pkt_valid = 0; parity_done = 0;
      {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = 3'b111;
      repeat (2) @(posedge clock);
      #1;
      m_state = S_DA;
      m_addr = 2'd0;
      n_cmp++;
      if (outs() !== O_DA) begin
         n_err++;
         $display("FAIL reset_hold: got %b expected %b", outs(), O_DA);
      end
      resetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
         n_cmp++;
         if (outs() !== O_DA) begin
            n_err++;
            $display("FAIL reset_release %0d: got %b expected %b", i, outs(), O_DA);
         end
      end
      // Mid-packet reset must take effect without a clock edge.
      apply(1'b1, 2'd0, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000);
      n_cmp++;
      if (outs() !== O_LFD) begin
         n_err++;
         $display("FAIL reset_pre_lfd: got %b expected %b", outs(), O_LFD);
      end
      #2 resetn = 1'b0;
      #1;
      m_state = S_DA;
      m_addr = 2'd0;
      n_cmp++;
      if (outs() !== O_DA) begin
         n_err++;
         $display("FAIL reset_async: got %b expected %b", outs(), O_DA);
      end
      resetn = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_normal_packet();
      logic [7:0] expv [5];
      expv = '{O_LFD, O_LD, O_LP, O_CPE, O_DA};
      for (int i = 0; i < 5; i++) begin
         apply(i == 0, 2'd1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
         n_cmp++;
         if (outs() !== expv[i]) begin
            n_err++;
            $display("FAIL normal_packet step %0d: got %b expected %b", i, outs(), expv[i]);
         end
      end
      $display("test_normal_packet done");
   endtask

   task automatic test_full_stall_end();
      logic [3:0] stim [7];   // {pkt_valid, fifo_full, low_pkt_valid, parity_done}
      logic [7:0] expv [7];
      stim = '{4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
      expv = '{O_LFD, O_LD, O_FFS, O_LAF, O_LP, O_CPE, O_DA};
      for (int i = 0; i < 7; i++) begin
         apply(stim[i][3], 2'd0, 3'b001, stim[i][2], stim[i][1], stim[i][0], 3'b000);
         n_cmp++;
         if (outs() !== expv[i]) begin
            n_err++;
            $display("FAIL full_stall_end step %0d: got %b expected %b", i, outs(), expv[i]);
         end
      end
      $display("test_full_stall_end done");
   endtask

   task automatic test_full_stall_continue();
      logic [3:0] stim [8];
      logic [7:0] expv [8];
      stim = '{4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
      expv = '{O_LFD, O_LD, O_FFS, O_LAF, O_LD, O_LP, O_CPE, O_DA};
      for (int i = 0; i < 8; i++) begin
         apply(stim[i][3], 2'd1, 3'b010, stim[i][2], stim[i][1], stim[i][0], 3'b000);
         n_cmp++;
         if (outs() !== expv[i]) begin
            n_err++;
            $display("FAIL full_stall_continue step %0d: got %b expected %b", i, outs(), expv[i]);
         end
      end
      $display("test_full_stall_continue done");
   endtask

   task automatic test_full_at_parity();
      logic [3:0] stim [7];
      logic [7:0] expv [7];
      stim = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
      expv = '{O_LFD, O_LD, O_LP, O_CPE, O_FFS, O_LAF, O_DA};
      for (int i = 0; i < 7; i++) begin
         apply(stim[i][3], 2'd2, 3'b100, stim[i][2], stim[i][1], stim[i][0], 3'b000);
         n_cmp++;
         if (outs() !== expv[i]) begin
            n_err++;
            $display("FAIL full_at_parity step %0d: got %b expected %b", i, outs(), expv[i]);
         end
      end
      $display("test_full_at_parity done");
   endtask

   task automatic test_busy_dest_soft_reset();
      logic [8:0] stim [10];  // {pkt_valid, data_in[1:0], fifo_empty[2:0], soft_reset[2:0]}
      logic [7:0] expv [10];
      stim = '{9'b1_10_011_000, 9'b1_10_011_000, 9'b1_10_111_000, 9'b1_10_111_000,
               9'b1_10_111_001, 9'b1_10_111_100, 9'b1_11_111_000, 9'b0_00_111_000,
               9'b1_01_000_000, 9'b1_01_000_010};
      expv = '{O_WTE, O_WTE, O_LFD, O_LD, O_LD, O_DA, O_DA, O_DA, O_WTE, O_DA};
      for (int i = 0; i < 10; i++) begin
         apply(stim[i][8], stim[i][7:6], stim[i][5:3], 1'b0, 1'b0, 1'b0, stim[i][2:0]);
         n_cmp++;
         if (outs() !== expv[i]) begin
            n_err++;
            $display("FAIL busy_dest_soft_reset step %0d: got %b expected %b", i, outs(), expv[i]);
         end
      end
      $display("test_busy_dest_soft_reset done");
   endtask

   task automatic test_random();
      int errs_before;
      errs_before = n_err;
      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
               {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0});
         n_cmp++;
         if (outs() !== exp_of(m_state)) begin
            n_err++;
            $display("FAIL random cycle %0d: got %b expected %b", i, outs(), exp_of(m_state));
         end
         if ($urandom_range(0, 249) == 0) begin
            #2 resetn = 1'b0;
            #1;
            m_state = S_DA;
            m_addr = 2'd0;
            n_cmp++;
            if (outs() !== O_DA) begin
               n_err++;
               $display("FAIL random_reset cycle %0d: got %b expected %b", i, outs(), O_DA);
            end
            resetn = 1'b1;
         end
      end
      $display("test_random done: %0d new errors", n_err - errs_before);
   endtask

   initial begin
      test_reset();
      test_normal_packet();
      test_full_stall_end();
      test_full_stall_continue();
      test_full_at_parity();
      test_busy_dest_soft_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
